// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode, ALU code and control-state definitions for myCPU
// Purpose: single source of opcodes, ALUOp encodings, instruction classes and the
//          multi-cycle control unit state type.
// Ports:   none (package).
package cpu_defs_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ORI  = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_OR   = 6'b010010;
   localparam logic [5:0] OP_MOVE = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LS,
      CLS_BR,
      CLS_HALT,
      CLS_ILL
   } op_class_t;

   typedef enum logic [3:0] {
      S_IF,
      S_ID,
      S_EXE_AL,
      S_EXE_LS,
      S_EXE_BR,
      S_MEM,
      S_WB_AL,
      S_WB_LD,
      S_HALT
   } cu_state_t;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode decoder for the multi-cycle control unit
// Purpose: maps the IR opcode to datapath selects and an instruction class.
// Ports:   op_i        opcode IR[31:26]
//          alu_op_o    ALU operation code
//          alu_src_b_o ALU B operand select (1 = extended immediate)
//          ext_sel_o   immediate extension (1 = sign, 0 = zero)
//          reg_out_o   write register select (1 = rd, 0 = rt)
//          is_store_o  opcode is sw
//          cls_o       instruction class steering the FSM
module cu_decode
   import cpu_defs_pkg::*;
(
   input  logic [5:0] op_i,
   output logic [2:0] alu_op_o,
   output logic       alu_src_b_o,
   output logic       ext_sel_o,
   output logic       reg_out_o,
   output logic       is_store_o,
   output op_class_t  cls_o
);

   always_comb begin
      alu_op_o    = ALU_ADD;
      alu_src_b_o = 1'b0;
      ext_sel_o   = 1'b0;
      reg_out_o   = 1'b0;
      is_store_o  = 1'b0;
      cls_o       = CLS_ILL;
      unique case (op_i)
         OP_ADD: begin
            reg_out_o = 1'b1;
            cls_o     = CLS_ALU;
         end
         OP_SUB: begin
            alu_op_o  = ALU_SUB;
            reg_out_o = 1'b1;
            cls_o     = CLS_ALU;
         end
         OP_ORI: begin
            alu_op_o    = ALU_OR;
            alu_src_b_o = 1'b1;
            cls_o       = CLS_ALU;
         end
         OP_AND: begin
            alu_op_o  = ALU_AND;
            reg_out_o = 1'b1;
            cls_o     = CLS_ALU;
         end
         OP_OR: begin
            alu_op_o  = ALU_OR;
            reg_out_o = 1'b1;
            cls_o     = CLS_ALU;
         end
         OP_MOVE: begin
            // rd = rs + $0: the datapath supplies $0 on the B port.
            reg_out_o = 1'b1;
            cls_o     = CLS_ALU;
         end
         OP_SW: begin
            alu_src_b_o = 1'b1;
            ext_sel_o   = 1'b1;
            is_store_o  = 1'b1;
            cls_o       = CLS_LS;
         end
         OP_LW: begin
            alu_src_b_o = 1'b1;
            ext_sel_o   = 1'b1;
            cls_o       = CLS_LS;
         end
         OP_BEQ: begin
            alu_op_o  = ALU_SUB;
            ext_sel_o = 1'b1;
            cls_o     = CLS_BR;
         end
         OP_HALT: cls_o = CLS_HALT;
         default: cls_o = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/multi_cycle_cu.sv
// rtl/multi_cycle_cu.sv - multi-cycle control unit sequencing IF/ID/EXE/MEM/WB
// Purpose: drives PC, IR, register file, ALU and data memory strobes per state,
//          counts retired instructions and reports halt/illegal status.
// Ports:   CLK, RST (sync, active-low); op opcode; zero ALU zero flag;
//          PCWre, PCSrc, InsMemRW, IRWre, ExtSel, ALUSrcB, ALUOp, RegOut,
//          RegWre, DataMemRW, ALUM2Reg datapath controls;
//          halted, illegal status; retired instruction counter.
module multi_cycle_cu
   import cpu_defs_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [5:0]       op,
   input  logic             zero,
   output logic             PCWre,
   output logic             PCSrc,
   output logic             InsMemRW,
   output logic             IRWre,
   output logic             ExtSel,
   output logic             ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic             RegOut,
   output logic             RegWre,
   output logic             DataMemRW,
   output logic             ALUM2Reg,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   cu_state_t        state_q, state_d;
   logic [CNT_W-1:0] retired_q;

   logic [2:0] dec_alu_op;
   logic       dec_src_b, dec_ext, dec_reg_out, dec_store;
   op_class_t  dec_cls;

   // Ungated strobes; reset masking is applied once at the outputs.
   logic pc_we, ir_we, reg_we, dmem_we;

   cu_decode u_decode (
      .op_i        (op),
      .alu_op_o    (dec_alu_op),
      .alu_src_b_o (dec_src_b),
      .ext_sel_o   (dec_ext),
      .reg_out_o   (dec_reg_out),
      .is_store_o  (dec_store),
      .cls_o       (dec_cls)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_IF;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (PCWre) retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      dmem_we  = 1'b0;
      PCSrc    = 1'b0;
      ALUM2Reg = 1'b0;
      halted   = 1'b0;
      illegal  = 1'b0;
      unique case (state_q)
         S_IF: begin
            ir_we   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            unique case (dec_cls)
               CLS_ALU:  state_d = S_EXE_AL;
               CLS_LS:   state_d = S_EXE_LS;
               CLS_BR:   state_d = S_EXE_BR;
               CLS_HALT: state_d = S_HALT;
               default: begin
                  // Undefined opcode: skip it and move on to the next word.
                  illegal = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_IF;
               end
            endcase
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_EXE_LS: state_d = S_MEM;
         S_EXE_BR: begin
            pc_we   = 1'b1;
            PCSrc   = zero;
            state_d = S_IF;
         end
         S_MEM: begin
            if (dec_store) begin
               dmem_we = 1'b1;
               pc_we   = 1'b1;
               state_d = S_IF;
            end else begin
               state_d = S_WB_LD;
            end
         end
         S_WB_AL: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            state_d = S_IF;
         end
         S_WB_LD: begin
            reg_we   = 1'b1;
            ALUM2Reg = 1'b1;
            pc_we    = 1'b1;
            state_d  = S_IF;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IF;
      endcase
   end

   // Decoded selects are only meaningful once the IR holds the new word.
   assign ALUOp   = (state_q == S_IF) ? 3'b000 : dec_alu_op;
   assign ALUSrcB = (state_q != S_IF) & dec_src_b;
   assign ExtSel  = (state_q != S_IF) & dec_ext;
   assign RegOut  = (state_q != S_IF) & dec_reg_out;

   // Holding reset low must never commit a partial PC/IR/register/memory write.
   assign PCWre     = pc_we & RST;
   assign IRWre     = ir_we & RST;
   assign RegWre    = reg_we & RST;
   assign DataMemRW = dmem_we & RST;

   assign InsMemRW = 1'b1;
   assign retired  = retired_q;

endmodule

// File: tb/tb_multi_cycle_cu.sv
// tb/tb_multi_cycle_cu.sv - self-checking bench for multi_cycle_cu
module tb_multi_cycle_cu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  op = 6'b0;
   logic        zero = 1'b0;

   logic        pcwre, pcsrc, insmem, irwre, extsel, srcb, regout, regwre, dmw, m2r, hlt, ill;
   logic [2:0]  aluop;
   logic [15:0] retired;

   logic        s_pcwre, s_pcsrc, s_insmem, s_irwre, s_extsel, s_srcb, s_regout;
   logic        s_regwre, s_dmw, s_m2r, s_hlt, s_ill;
   logic [2:0]  s_aluop;
   logic [2:0]  s_retired;

   always #5 clk = ~clk;

   multi_cycle_cu dut (
      .CLK(clk), .RST(rst_n), .op(op), .zero(zero),
      .PCWre(pcwre), .PCSrc(pcsrc), .InsMemRW(insmem), .IRWre(irwre),
      .ExtSel(extsel), .ALUSrcB(srcb), .ALUOp(aluop), .RegOut(regout),
      .RegWre(regwre), .DataMemRW(dmw), .ALUM2Reg(m2r),
      .halted(hlt), .illegal(ill), .retired(retired)
   );

   // Narrow-counter copy driven with identical stimulus, used to reach the wrap point quickly.
   multi_cycle_cu #(.CNT_W(3)) dut_s (
      .CLK(clk), .RST(rst_n), .op(op), .zero(zero),
      .PCWre(s_pcwre), .PCSrc(s_pcsrc), .InsMemRW(s_insmem), .IRWre(s_irwre),
      .ExtSel(s_extsel), .ALUSrcB(s_srcb), .ALUOp(s_aluop), .RegOut(s_regout),
      .RegWre(s_regwre), .DataMemRW(s_dmw), .ALUM2Reg(s_m2r),
      .halted(s_hlt), .illegal(s_ill), .retired(s_retired)
   );

   logic [14:0] outv;
   assign outv = {insmem, pcwre, pcsrc, irwre, extsel, srcb, aluop, regout, regwre, dmw, m2r, hlt, ill};

   typedef struct {
      string            name;
      logic [5:0]       op;
      logic             zero;
      int               ncyc;
      logic [4:0][14:0] exp;
   } vec_t;

   vec_t tv [11];
   int   tests = 0;
   int   fails = 0;
   int   exp_ret = 0;

   function automatic logic [14:0] row(input logic pcw, input logic pcs, input logic irw,
                                       input logic ext, input logic sb, input logic [2:0] ao,
                                       input logic ro, input logic rw, input logic dw,
                                       input logic mr, input logic h, input logic il);
      return {1'b1, pcw, pcs, irw, ext, sb, ao, ro, rw, dw, mr, h, il};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input string nm, input logic [5:0] o, input logic z,
                          input int n, input logic [14:0] r0, input logic [14:0] r1,
                          input logic [14:0] r2, input logic [14:0] r3, input logic [14:0] r4);
      tv[i].name = nm;
      tv[i].op   = o;
      tv[i].zero = z;
      tv[i].ncyc = n;
      tv[i].exp  = {r4, r3, r2, r1, r0};
   endtask

   // Starts and ends on a falling edge; the first cycle is IF.
   task automatic run_vec(input int i);
      for (int c = 0; c < tv[i].ncyc; c++) begin
         if (c == 0) begin
            op   = tv[i].op;
            zero = tv[i].zero;
         end
         #1;
         chk($sformatf("%s_c%0d", tv[i].name, c + 1), 32'(outv), 32'(tv[i].exp[c]));
         if (c == 0) begin
            chk($sformatf("%s_ret", tv[i].name), 32'(retired), 32'(exp_ret));
            chk($sformatf("%s_ret_s", tv[i].name), 32'(s_retired), 32'(exp_ret % 8));
         end
         @(negedge clk);
      end
      exp_ret++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ret = 0;
   endtask

   logic [14:0] ifr;

   initial begin
      ifr = row(0,0,1, 0,0,3'b000, 0,0,0,0, 0,0);
      set_vec(0, "add", 6'b000000, 0, 4, ifr, row(0,0,0,0,0,3'b000,1,0,0,0,0,0),
              row(0,0,0,0,0,3'b000,1,0,0,0,0,0), row(1,0,0,0,0,3'b000,1,1,0,0,0,0), '0);
      set_vec(1, "sub", 6'b000001, 0, 4, ifr, row(0,0,0,0,0,3'b001,1,0,0,0,0,0),
              row(0,0,0,0,0,3'b001,1,0,0,0,0,0), row(1,0,0,0,0,3'b001,1,1,0,0,0,0), '0);
      set_vec(2, "ori", 6'b010000, 1, 4, ifr, row(0,0,0,0,1,3'b011,0,0,0,0,0,0),
              row(0,0,0,0,1,3'b011,0,0,0,0,0,0), row(1,0,0,0,1,3'b011,0,1,0,0,0,0), '0);
      set_vec(3, "and", 6'b010001, 0, 4, ifr, row(0,0,0,0,0,3'b100,1,0,0,0,0,0),
              row(0,0,0,0,0,3'b100,1,0,0,0,0,0), row(1,0,0,0,0,3'b100,1,1,0,0,0,0), '0);
      set_vec(4, "or", 6'b010010, 0, 4, ifr, row(0,0,0,0,0,3'b011,1,0,0,0,0,0),
              row(0,0,0,0,0,3'b011,1,0,0,0,0,0), row(1,0,0,0,0,3'b011,1,1,0,0,0,0), '0);
      set_vec(5, "move", 6'b100000, 0, 4, ifr, row(0,0,0,0,0,3'b000,1,0,0,0,0,0),
              row(0,0,0,0,0,3'b000,1,0,0,0,0,0), row(1,0,0,0,0,3'b000,1,1,0,0,0,0), '0);
      set_vec(6, "lw", 6'b100111, 0, 5, ifr, row(0,0,0,1,1,3'b000,0,0,0,0,0,0),
              row(0,0,0,1,1,3'b000,0,0,0,0,0,0), row(0,0,0,1,1,3'b000,0,0,0,0,0,0),
              row(1,0,0,1,1,3'b000,0,1,0,1,0,0));
      set_vec(7, "sw", 6'b100110, 0, 4, ifr, row(0,0,0,1,1,3'b000,0,0,0,0,0,0),
              row(0,0,0,1,1,3'b000,0,0,0,0,0,0), row(1,0,0,1,1,3'b000,0,0,1,0,0,0), '0);
      set_vec(8, "beq_t", 6'b110000, 1, 3, ifr, row(0,0,0,1,0,3'b001,0,0,0,0,0,0),
              row(1,1,0,1,0,3'b001,0,0,0,0,0,0), '0, '0);
      set_vec(9, "beq_nt", 6'b110000, 0, 3, ifr, row(0,0,0,1,0,3'b001,0,0,0,0,0,0),
              row(1,0,0,1,0,3'b001,0,0,0,0,0,0), '0, '0);
      set_vec(10, "illegal", 6'b010011, 0, 2, ifr, row(1,0,0,0,0,3'b000,0,0,0,0,0,1),
              '0, '0, '0);

      // Reset state, including forced-low strobes while reset is held.
      @(negedge clk);
      #1;
      chk("rst_held_irwre", 32'(irwre), 32'(0));
      @(negedge clk);
      do_reset();
      #1;
      chk("rst_outputs", 32'(outv), 32'(ifr));
      chk("rst_retired", 32'(retired), 32'(0));

      for (int i = 0; i < 11; i++) run_vec(i);

      // halt: IF, ID, then HALT forever; op changes and time do not release it.
      op = 6'b111111;
      #1;
      chk("halt_if", 32'(outv), 32'(ifr));
      chk("halt_ret_before", 32'(retired), 32'(exp_ret));
      @(negedge clk);
      #1;
      chk("halt_id", 32'(outv), 32'(row(0,0,0,0,0,3'b000,0,0,0,0,0,0)));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 3) op = 6'b000000;
         #1;
         if (k < 3)
            chk($sformatf("halt_st%0d", k), 32'(outv), 32'(row(0,0,0,0,0,3'b000,0,0,0,0,1,0)));
         else
            chk($sformatf("halt_st%0d", k), 32'(outv), 32'(row(0,0,0,0,0,3'b000,1,0,0,0,1,0)));
         chk($sformatf("halt_ret%0d", k), 32'(retired), 32'(exp_ret));
      end

      // Reset during MEM of sw: no store, PC held, counter cleared.
      @(negedge clk);
      do_reset();
      run_vec(0);
      op = 6'b100110;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mem_outputs", 32'(outv), 32'(row(0,0,0,1,1,3'b000,0,0,0,0,0,0)));
      @(negedge clk);
      rst_n = 1'b1;
      exp_ret = 0;
      #1;
      chk("rst_mem_after_state", 32'(outv), 32'(ifr));
      chk("rst_mem_after_ret", 32'(retired), 32'(0));

      // Counter wrap on the 3-bit copy: seven adds reach 7, the eighth wraps to 0.
      for (int k = 0; k < 7; k++) run_vec(0);
      #1;
      chk("wrap_pre_s", 32'(s_retired), 32'(7));
      #1;
      op = 6'b000000;
      run_vec(0);
      #1;
      chk("wrap_post_s", 32'(s_retired), 32'(0));
      chk("wrap_post_wide", 32'(retired), 32'(8));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
